// File: rtl/ide_cycle_ctrl_if.sv
// ide_cycle_ctrl_if: 68030 bus-cycle inputs and IDE control outputs of the IDE cycle sequencer
interface ide_cycle_ctrl_if;
    logic nAS;
    logic nDS;
    logic RnW;
    logic ideBank;
    logic nIdeCE;
    logic nIdeIO16;
    logic nIdeCS1;
    logic nIdeCS3;
    logic nIORd;
    logic nIOWr;
    logic nIdeBufEn;
    modport master (
        output nAS, nDS, RnW, ideBank, nIdeCE, nIdeIO16,
        input  nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn
    );
    modport slave (
        input  nAS, nDS, RnW, ideBank, nIdeCE, nIdeIO16,
        output nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn
    );
endinterface

// File: rtl/ide_cycle_ctrl.sv
// ide_cycle_ctrl: IDE/ATA PIO cycle sequencer producing CS, strobes, buffer enable and sized DSACK
module ide_cycle_ctrl #(
    parameter int SETUP_CLKS    = 2,
    parameter int STROBE_CLKS   = 4,
    parameter int HOLD_CLKS     = 1,
    parameter int RECOVERY_CLKS = 3
) (
    input  logic            sysClk,
    input  logic            nReset,
    ide_cycle_ctrl_if.slave bus,
    inout  wire [1:0]       znDsack
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, HOLD, RECOVER} state_e;
    localparam logic [3:0] SETUP_N  = 4'(SETUP_CLKS - 1);
    localparam logic [3:0] STROBE_N = 4'(STROBE_CLKS - 1);
    localparam logic [3:0] HOLD_N   = 4'(HOLD_CLKS - 1);
    localparam logic [3:0] REC_N    = 4'(RECOVERY_CLKS - 1);
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       bank_q, bank_d, rd_q, rd_d, w16_q, w16_d;
    logic       cs1_q, cs1_d, cs3_q, cs3_d, ior_q, ior_d, iow_q, iow_d, buf_q, buf_d;
    logic       start, done, cs_act, stb_act;
    assign start = !bus.nAS && !bus.nIdeCE;
    assign done  = cnt_q == 4'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = done ? 4'd0 : cnt_q - 4'd1;
        bank_d  = bank_q;
        rd_d    = rd_q;
        w16_d   = w16_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_N;
                    bank_d  = bus.ideBank;
                    rd_d    = bus.RnW;
                    w16_d   = bus.nIdeIO16;
                end
            end
            SETUP: begin
                if (bus.nAS) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_N;
                end else if (done && (rd_q || !bus.nDS)) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_N;
                end
            end
            STROBE: begin
                if (bus.nAS) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_N;
                end else if (done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (bus.nAS) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_N;
                end
            end
            HOLD: begin
                if (done) begin
                    state_d = RECOVER;
                    cnt_d   = REC_N;
                end
            end
            RECOVER: state_d = done ? IDLE : RECOVER;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they change cleanly on the clock edge
        cs_act  = state_d inside {SETUP, STROBE, ACK, HOLD};
        stb_act = state_d inside {STROBE, ACK};
        cs1_d   = !(cs_act && !bank_d);
        cs3_d   = !(cs_act && bank_d);
        ior_d   = !(stb_act && rd_d);
        iow_d   = !(stb_act && !rd_d);
        buf_d   = !cs_act;
    end
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            bank_q  <= 1'b0;
            rd_q    <= 1'b0;
            w16_q   <= 1'b0;
            cs1_q   <= 1'b1;
            cs3_q   <= 1'b1;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            buf_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            rd_q    <= rd_d;
            w16_q   <= w16_d;
            cs1_q   <= cs1_d;
            cs3_q   <= cs3_d;
            ior_q   <= ior_d;
            iow_q   <= iow_d;
            buf_q   <= buf_d;
        end
    end
    assign bus.nIdeCS1   = cs1_q;
    assign bus.nIdeCS3   = cs3_q;
    assign bus.nIORd     = ior_q;
    assign bus.nIOWr     = iow_q;
    assign bus.nIdeBufEn = buf_q;
    // DSACK1 terminates a 16-bit port, DSACK0 an 8-bit one; released the moment nAS rises
    assign znDsack = (state_q == ACK && !bus.nAS) ? (w16_q ? 2'bz0 : 2'b0z) : 2'bzz;
endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// tb_ide_cycle_ctrl: directed scoreboard bench for the IDE cycle sequencer at default timing
module tb_ide_cycle_ctrl;
    typedef struct {
        int         at;
        logic [6:0] v;
    } exp_t;
    // {nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn, DSACK1, DSACK0}; released DSACK reads 1 via pullups
    localparam logic [6:0] O_IDLE  = 7'b1111111;
    localparam logic [6:0] R_SET   = 7'b0111011;
    localparam logic [6:0] R_STB   = 7'b0101011;
    localparam logic [6:0] R_ACK16 = 7'b0101001;
    localparam logic [6:0] R_ACK8  = 7'b0101010;
    localparam logic [6:0] W_SET   = 7'b1011011;
    localparam logic [6:0] W_STB   = 7'b1010011;
    localparam logic [6:0] W_ACK8  = 7'b1010010;
    logic       sysClk = 1'b0;
    logic       nReset;
    wire  [1:0] znDsack;
    logic [6:0] got;
    exp_t       q[$];
    string      qn[$];
    exp_t       e;
    string      nm;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         s;
    pullup (znDsack[0]);
    pullup (znDsack[1]);
    ide_cycle_ctrl_if bus ();
    ide_cycle_ctrl dut (
        .sysClk (sysClk),
        .nReset (nReset),
        .bus    (bus),
        .znDsack(znDsack)
    );
    always #5 sysClk = ~sysClk;
    assign got = {bus.nIdeCS1, bus.nIdeCS3, bus.nIORd, bus.nIOWr, bus.nIdeBufEn, znDsack};
    always @(negedge sysClk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            total++;
            if (e.at != cyc || got !== e.v) begin
                bad++;
                $display("FAIL %s cyc=%0d due=%0d got=%b want=%b", nm, cyc, e.at, got, e.v);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysClk);
            #1;
            cyc++;
        end
    endtask
    task automatic expect_n(input int at, input string name, input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{at + i, v});
            qn.push_back(name);
        end
    endtask
    task automatic start_cycle(input logic rnw, input logic bank, input logic io16, input logic ds);
        bus.RnW      = rnw;
        bus.ideBank  = bank;
        bus.nIdeIO16 = io16;
        bus.nDS      = ds;
        bus.nIdeCE   = 1'b0;
        bus.nAS      = 1'b0;
    endtask
    task automatic end_cycle();
        bus.nAS    = 1'b1;
        bus.nDS    = 1'b1;
        bus.nIdeCE = 1'b1;
    endtask
    initial begin
        nReset       = 1'b0;
        bus.nAS      = 1'b1;
        bus.nDS      = 1'b1;
        bus.RnW      = 1'b1;
        bus.ideBank  = 1'b0;
        bus.nIdeCE   = 1'b1;
        bus.nIdeIO16 = 1'b1;
        expect_n(1, "reset", O_IDLE, 2);
        tick(2);
        nReset = 1'b1;
        // asynchronous reset in the middle of STROBE
        s = cyc + 1;
        start_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_n(s, "rst_setup", R_SET, 2);
        expect_n(s + 2, "rst_strobe", R_STB, 1);
        expect_n(s + 3, "rst_async", O_IDLE, 6);
        tick(4);
        nReset = 1'b0;
        end_cycle();
        tick(1);
        nReset = 1'b1;
        tick(5);
        // 16-bit read, command block
        s = cyc + 1;
        start_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_n(s, "rd_setup", R_SET, 2);
        expect_n(s + 2, "rd_strobe", R_STB, 4);
        expect_n(s + 6, "rd_ack16", R_ACK16, 1);
        expect_n(s + 7, "rd_release", R_STB, 1);
        expect_n(s + 8, "rd_hold", R_SET, 1);
        expect_n(s + 9, "rd_recover", O_IDLE, 4);
        tick(8);
        end_cycle();
        tick(6);
        // 8-bit write, control block, late nDS, bank/CE changes ignored
        s = cyc + 1;
        start_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        expect_n(s, "wr_setup", W_SET, 3);
        expect_n(s + 3, "wr_strobe", W_STB, 4);
        expect_n(s + 7, "wr_ack8", W_ACK8, 2);
        expect_n(s + 9, "wr_release", W_STB, 1);
        expect_n(s + 10, "wr_hold", W_SET, 1);
        expect_n(s + 11, "wr_recover", O_IDLE, 4);
        tick(2);
        bus.ideBank = 1'b0;
        bus.nIdeCE  = 1'b1;
        tick(1);
        bus.nDS = 1'b0;
        tick(1);
        bus.nDS = 1'b1;
        tick(6);
        end_cycle();
        bus.RnW = 1'b1;
        tick(6);
        // back-to-back reads, second request arrives during RECOVER
        s = cyc + 1;
        start_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_n(s, "b2b_setup1", R_SET, 2);
        expect_n(s + 2, "b2b_strobe1", R_STB, 4);
        expect_n(s + 6, "b2b_ack1", R_ACK16, 1);
        expect_n(s + 7, "b2b_rel1", R_STB, 1);
        expect_n(s + 8, "b2b_hold1", R_SET, 1);
        expect_n(s + 9, "b2b_wait", O_IDLE, 4);
        expect_n(s + 13, "b2b_setup2", R_SET, 2);
        expect_n(s + 15, "b2b_strobe2", R_STB, 4);
        expect_n(s + 19, "b2b_ack2", R_ACK8, 1);
        expect_n(s + 20, "b2b_rel2", R_STB, 1);
        expect_n(s + 21, "b2b_hold2", R_SET, 1);
        expect_n(s + 22, "b2b_recover2", O_IDLE, 4);
        tick(8);
        end_cycle();
        tick(2);
        start_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        tick(11);
        end_cycle();
        tick(6);
        // abort during STROBE
        s = cyc + 1;
        start_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_n(s, "ab_setup", R_SET, 2);
        expect_n(s + 2, "ab_strobe", R_STB, 1);
        expect_n(s + 3, "ab_hold", R_SET, 1);
        expect_n(s + 4, "ab_recover", O_IDLE, 5);
        tick(3);
        end_cycle();
        tick(7);
        // nAS without the IDE decode
        s = cyc + 1;
        bus.nAS = 1'b0;
        expect_n(s, "no_ce", O_IDLE, 20);
        tick(20);
        bus.nAS = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick(1);
        if (q.size() > 0) begin
            $display("FAIL drain pending=%0d want=0", q.size());
            bad += q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
